// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, field positions and exception codes.
package cp0_pkg;

   localparam logic [4:0] REG_SR    = 5'd12;
   localparam logic [4:0] REG_CAUSE = 5'd13;
   localparam logic [4:0] REG_EPC   = 5'd14;
   localparam logic [4:0] REG_PRID  = 5'd15;

   localparam int SR_IE        = 0;
   localparam int SR_EXL       = 1;
   localparam int SR_IM_LO     = 10;
   localparam int SR_IM_HI     = 15;
   localparam int CAUSE_EXC_LO = 2;
   localparam int CAUSE_EXC_HI = 6;
   localparam int CAUSE_IP_LO  = 10;
   localparam int CAUSE_IP_HI  = 15;
   localparam int CAUSE_BD     = 31;

   localparam logic [4:0] EXC_INT  = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_RI   = 5'd10;
   localparam logic [4:0] EXC_OV   = 5'd12;

   typedef struct packed {
      logic [5:0] im;
      logic       exl;
      logic       ie;
   } sr_t;

endpackage

// File: rtl/cp0_req_gen.sv
// Combinational exception/interrupt request logic; interrupts outrank synchronous exceptions.
module cp0_req_gen
   import cp0_pkg::*;
(
   input  logic       enable,
   input  logic [5:0] hw_int,
   input  logic [5:0] im,
   input  logic       ie,
   input  logic       exl,
   input  logic [4:0] exc_code_in,
   output logic       int_req,
   output logic       exc_req,
   output logic       req,
   output logic [4:0] exc_code
);

   // enable is the deasserted reset, so req drops the instant reset asserts
   assign int_req  = enable & (|(hw_int & im)) & ie & ~exl;
   assign exc_req  = enable & (exc_code_in != EXC_INT) & ~exl;
   assign req      = int_req | exc_req;
   assign exc_code = int_req ? EXC_INT : exc_code_in;

endmodule

// File: rtl/cp0.sv
// Coprocessor 0: SR, Cause, EPC and PRId with precise exception entry and eret.
module cp0
   import cp0_pkg::*;
#(
   parameter logic [31:0] PRID_VAL   = 32'h2022_0007,
   parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  A1,
   input  logic [4:0]  A2,
   input  logic [31:0] DIn,
   input  logic        WE,
   input  logic [31:0] VPC,
   input  logic        BDIn,
   input  logic [4:0]  ExcCodeIn,
   input  logic [5:0]  HWInt,
   input  logic        EXLClr,
   output logic [31:0] DOut,
   output logic [31:0] EPCOut,
   output logic        Req,
   output logic [31:0] handler_pc
);

   sr_t         sr;
   logic        cause_bd;
   logic [5:0]  cause_ip;
   logic [4:0]  cause_exc;
   logic [31:0] epc;

   logic        int_req;
   logic        exc_req;
   logic [4:0]  exc_code;
   logic [31:0] sr_word;
   logic [31:0] cause_word;
   logic [31:0] victim_pc;

   cp0_req_gen u_req_gen (
      .enable      (reset),
      .hw_int      (HWInt),
      .im          (sr.im),
      .ie          (sr.ie),
      .exl         (sr.exl),
      .exc_code_in (ExcCodeIn),
      .int_req     (int_req),
      .exc_req     (exc_req),
      .req         (Req),
      .exc_code    (exc_code)
   );

   assign sr_word    = {16'b0, sr.im, 8'b0, sr.exl, sr.ie};
   assign cause_word = {cause_bd, 15'b0, cause_ip, 3'b0, cause_exc, 2'b0};
   // a delay-slot victim restarts at its branch so the branch re-executes
   assign victim_pc  = (VPC & 32'hFFFF_FFFC) - (BDIn ? 32'd4 : 32'd0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sr        <= '0;
         cause_bd  <= 1'b0;
         cause_ip  <= 6'b0;
         cause_exc <= 5'b0;
         epc       <= 32'b0;
      end else begin
         cause_ip <= HWInt;
         if (Req) begin
            cause_exc <= exc_code;
            cause_bd  <= BDIn;
            epc       <= victim_pc;
            sr.exl    <= 1'b1;
         end else begin
            if (EXLClr)
               sr.exl <= 1'b0;
            // an SR write in the same cycle as eret overrides the clear
            if (WE) begin
               case (A2)
                  REG_SR:  sr  <= '{im: DIn[SR_IM_HI:SR_IM_LO], exl: DIn[SR_EXL], ie: DIn[SR_IE]};
                  REG_EPC: epc <= DIn & 32'hFFFF_FFFC;
                  default: ;
               endcase
            end
         end
      end
   end

   always_comb begin
      DOut = 32'b0;
      case (A1)
         REG_SR:    DOut = sr_word;
         REG_CAUSE: DOut = cause_word;
         REG_EPC:   DOut = epc;
         REG_PRID:  DOut = PRID_VAL;
         default:   DOut = 32'b0;
      endcase
   end

   assign EPCOut     = epc;
   assign handler_pc = HANDLER_PC;

endmodule

// File: tb/tb_cp0.sv
// Directed and randomized checks of cp0 against a register-level behavioural model.
module tb_cp0;

   localparam logic [31:0] PRID = 32'h2022_0007;
   localparam logic [31:0] HPC  = 32'h0000_4180;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  A1, A2, ExcCodeIn;
   logic [31:0] DIn, VPC;
   logic        WE, BDIn, EXLClr;
   logic [5:0]  HWInt;
   wire  [31:0] DOut, EPCOut, handler_pc;
   wire         Req;

   int vectors = 0;
   int fails   = 0;

   logic [31:0] m_sr, m_cause, m_epc;
   logic [4:0]  codes [4] = '{5'd4, 5'd5, 5'd10, 5'd12};
   logic [4:0]  regs  [4] = '{5'd12, 5'd14, 5'd13, 5'd3};

   cp0 dut (
      .clk        (clk),
      .reset      (reset),
      .A1         (A1),
      .A2         (A2),
      .DIn        (DIn),
      .WE         (WE),
      .VPC        (VPC),
      .BDIn       (BDIn),
      .ExcCodeIn  (ExcCodeIn),
      .HWInt      (HWInt),
      .EXLClr     (EXLClr),
      .DOut       (DOut),
      .EPCOut     (EPCOut),
      .Req        (Req),
      .handler_pc (handler_pc)
   );

   always #50 clk = ~clk;

   function automatic logic m_int();
      return (|(HWInt & m_sr[15:10])) && m_sr[0] && !m_sr[1];
   endfunction

   function automatic logic m_req();
      return reset && (m_int() || (ExcCodeIn != 5'd0 && !m_sr[1]));
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] a);
      case (a)
         5'd12:   return m_sr;
         5'd13:   return m_cause;
         5'd14:   return m_epc;
         5'd15:   return PRID;
         default: return 32'd0;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
      A1 = a;
      #1;
      chk(tag, DOut, exp);
   endtask

   task automatic idle();
      WE = 1'b0; A2 = 5'd0; DIn = 32'd0; ExcCodeIn = 5'd0; HWInt = 6'd0;
      EXLClr = 1'b0; BDIn = 1'b0; VPC = 32'd0; A1 = 5'd0;
   endtask

   // advance one clock edge, updating the model from the inputs that were present before it
   task automatic tick();
      logic [31:0] ns, nc, ne;
      logic [4:0]  code;
      ns = m_sr;
      ne = m_epc;
      nc = (m_cause & ~32'h0000_FC00) | ({26'd0, HWInt} << 10);
      if (m_req()) begin
         code = m_int() ? 5'd0 : ExcCodeIn;
         nc = (BDIn ? 32'h8000_0000 : 32'd0) + ({26'd0, HWInt} << 10) + ({27'd0, code} << 2);
         ne = (VPC & ~32'd3) - (BDIn ? 32'd4 : 32'd0);
         ns = m_sr | 32'd2;
      end else begin
         if (EXLClr) ns = ns & ~32'd2;
         if (WE && A2 == 5'd12) ns = DIn & 32'h0000_FC03;
         if (WE && A2 == 5'd14) ne = DIn & ~32'd3;
      end
      @(posedge clk);
      m_sr = ns; m_cause = nc; m_epc = ne;
      #1;
   endtask

   initial begin
      idle();
      reset = 1'b0;
      ExcCodeIn = 5'd12;
      m_sr = 0; m_cause = 0; m_epc = 0;
      #2;
      chk("reset_req", {31'd0, Req}, 32'd0);
      chk("reset_epc", EPCOut, 32'd0);
      rd("reset_sr", 5'd12, 32'd0);
      rd("reset_cause", 5'd13, 32'd0);
      @(posedge clk); #1;
      idle();
      reset = 1'b1;
      #1;
      chk("handler_pc", handler_pc, HPC);

      // interrupt entry
      WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_0401;
      tick();
      WE = 1'b0; HWInt = 6'b000001; VPC = 32'h3008;
      #1;
      chk("int_req", {31'd0, Req}, 32'd1);
      tick();
      chk("int_epc", EPCOut, 32'h3008);
      rd("int_cause", 5'd13, 32'h0000_0400);
      rd("int_sr", 5'd12, 32'h0000_0403);
      chk("int_req_after", {31'd0, Req}, 32'd0);

      // no nesting while EXL=1, then eret
      HWInt = 6'd0; ExcCodeIn = 5'd10;
      #1;
      chk("nest_req", {31'd0, Req}, 32'd0);
      tick();
      chk("nest_epc", EPCOut, 32'h3008);
      rd("nest_cause", 5'd13, 32'd0);
      ExcCodeIn = 5'd0; EXLClr = 1'b1;
      tick();
      EXLClr = 1'b0;
      rd("eret_sr", 5'd12, 32'h0000_0401);

      // overflow in a delay slot
      ExcCodeIn = 5'd12; VPC = 32'h3020; BDIn = 1'b1;
      #1;
      chk("ov_req", {31'd0, Req}, 32'd1);
      tick();
      chk("ov_epc", EPCOut, 32'h301C);
      rd("ov_cause", 5'd13, 32'h8000_0030);
      ExcCodeIn = 5'd0; BDIn = 1'b0; EXLClr = 1'b1;
      tick();
      EXLClr = 1'b0;

      // exception discards a simultaneous mtc0 to EPC
      WE = 1'b1; A2 = 5'd14; DIn = 32'h3007; ExcCodeIn = 5'd4; VPC = 32'h3040;
      #1;
      chk("adel_req", {31'd0, Req}, 32'd1);
      tick();
      chk("adel_epc", EPCOut, 32'h3040);
      rd("adel_cause", 5'd13, 32'h0000_0010);
      WE = 1'b0; ExcCodeIn = 5'd0; EXLClr = 1'b1;
      tick();
      EXLClr = 1'b0;

      // SR write masking, EXL set by mtc0 suppresses Req, PRId and unimplemented reads
      WE = 1'b1; A2 = 5'd12; DIn = 32'hFFFF_FFFF;
      tick();
      WE = 1'b0;
      rd("sr_mask", 5'd12, 32'h0000_FC03);
      HWInt = 6'h3F;
      #1;
      chk("sr_exl_req", {31'd0, Req}, 32'd0);
      rd("prid", 5'd15, PRID);
      rd("unimpl", 5'd3, 32'd0);
      HWInt = 6'd0;

      // asynchronous reset mid-run
      WE = 1'b1; A2 = 5'd14; DIn = 32'h3010;
      tick();
      WE = 1'b0;
      chk("epc_write", EPCOut, 32'h3010);
      ExcCodeIn = 5'd5;
      reset = 1'b0;
      #1;
      chk("arst_epc", EPCOut, 32'd0);
      chk("arst_req", {31'd0, Req}, 32'd0);
      rd("arst_sr", 5'd12, 32'd0);
      rd("arst_cause", 5'd13, 32'd0);
      m_sr = 0; m_cause = 0; m_epc = 0;
      @(posedge clk); #1;
      idle();
      reset = 1'b1;
      #1;

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         ExcCodeIn = ($urandom_range(0, 9) == 0) ? codes[$urandom_range(0, 3)] : 5'd0;
         EXLClr    = ($urandom_range(0, 3) == 0);
         WE        = !EXLClr && ($urandom_range(0, 2) == 0);
         A2        = regs[$urandom_range(0, 3)];
         DIn       = $urandom;
         HWInt     = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom_range(0, 63));
         VPC       = $urandom;
         BDIn      = 1'($urandom_range(0, 1));
         A1        = 5'($urandom_range(10, 16));
         #1;
         chk("rnd_req", {31'd0, Req}, {31'd0, m_req()});
         chk("rnd_dout", DOut, m_read(A1));
         chk("rnd_epc", EPCOut, m_epc);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule

// File: doc/cp0.md
CP0 -- requirements
Module: cp0

Interface
REQ-001 Parameter PRID_VAL, default 32'h2022_0007, SHALL be the value returned for register 15 (PRId).
REQ-002 Parameter HANDLER_PC, default 32'h0000_4180, SHALL be the exception entry address driven on handler_pc.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 A1  input  5  read register number (12/13/14/15).
REQ-006 A2  input  5  write register number (mtc0 target).
REQ-007 DIn  input  32  mtc0 write data.
REQ-008 WE  input  1  mtc0 write enable, from the M-stage instruction.
REQ-009 VPC  input  32  PC of the M-stage (victim) instruction.
REQ-010 BDIn  input  1  victim instruction is in a branch delay slot.
REQ-011 ExcCodeIn  input  5  M-stage synchronous exception code; 0 means none.
REQ-012 HWInt  input  6  external hardware interrupt lines, level-sensitive.
REQ-013 EXLClr  input  1  eret is in M stage.
REQ-014 DOut  output  32  combinational read of register A1; 0 for unimplemented numbers.
REQ-015 EPCOut  output  32  current EPC, the eret target.
REQ-016 Req  output  1  flush request to all pipeline registers and PC.
REQ-017 handler_pc  output  32  constant HANDLER_PC.

Function
REQ-018 SR (12) SHALL hold IM[15:10], EXL[1], IE[0]; all other bits SHALL read 0 and ignore writes.
REQ-019 Cause (13) SHALL hold BD[31], IP[15:10], ExcCode[6:2]; all other bits SHALL read 0; Cause SHALL be read-only to mtc0.
REQ-020 IntReq SHALL be |(HWInt & SR.IM) & SR.IE & ~SR.EXL.
REQ-021 ExcReq SHALL be (ExcCodeIn != 0) & ~SR.EXL.
REQ-022 Req SHALL be IntReq | ExcReq and SHALL be purely combinational, with zero-cycle latency.
REQ-023 On a clock edge with Req=1, Cause.ExcCode SHALL load 0 if IntReq=1, otherwise ExcCodeIn; interrupts take priority.
REQ-024 On a clock edge with Req=1, Cause.BD SHALL load BDIn, EPC SHALL load {VPC[31:2],2'b00} - (BDIn ? 4 : 0), and SR.EXL SHALL set to 1.
REQ-025 Cause.IP SHALL sample HWInt on every clock edge, independent of Req and EXL.
REQ-026 On a clock edge with EXLClr=1 and Req=0, SR.EXL SHALL clear to 0.
REQ-027 On a clock edge with WE=1 and Req=0, SR (A2=12) or EPC (A2=14, bits [1:0] forced to 0) SHALL update from DIn; writes to other numbers SHALL be ignored.
REQ-028 When Req=1 in the same cycle as WE or EXLClr, Req SHALL win and the mtc0/eret effect SHALL be discarded.
REQ-029 While EXL=1, a nonzero ExcCodeIn or pending interrupt SHALL NOT assert Req or modify state other than Cause.IP (no nesting).
REQ-030 A write to SR that sets EXL=1 in the same edge SHALL suppress Req from the next cycle onward.

Reset
REQ-031 While reset=0, SR, Cause and EPC SHALL be 0 and Req SHALL be 0 immediately, without waiting for a clock edge.
REQ-032 Release of reset SHALL take effect at the next rising edge; no state SHALL update on that edge before release.

Structure
REQ-033 A shared package SHALL hold the register numbers (12-15), SR/Cause bit positions, and ExcCode constants (Int=0, AdEL=4, AdES=5, RI=10, Ov=12).
REQ-034 One sub-module, cp0_req_gen, SHALL compute IntReq, ExcReq, Req and the ExcCode to record; cp0 SHALL instantiate it once.

Verification
REQ-035 Reset low mid-run with EPC=0x3010 -> EPC, SR, Cause read 0 and Req=0 at once, before any clock edge.
REQ-036 SR=0x0000_0401, HWInt=6'b000001, VPC=0x3008, BDIn=0 -> Req=1; next cycle EPC=0x3008, ExcCode=0, EXL=1, Req=0.
REQ-037 ExcCodeIn=12, VPC=0x3020, BDIn=1 -> Req=1; then EPC=0x301C, BD=1, ExcCode=12.
REQ-038 EXL=1 and ExcCodeIn=10 -> Req stays 0 and EPC is unchanged; then EXLClr=1 -> EXL=0 on the next edge.
REQ-039 WE=1, A2=14, DIn=0x3007, with ExcCodeIn=4 in the same cycle -> EPC=VPC (not 0x3004), ExcCode=4.
REQ-040 WE=1, A2=12, DIn=0xFFFF_FFFF -> SR reads 0x0000_FC03; A1=15 reads PRID_VAL; A1=3 reads 0.
